// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, constants and helpers for the LCD bus scheduler
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int RS_BIT = 9;

    localparam logic [7:0] LCD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_HOME    = 8'h02;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_DISP_ON = 8'h0D;
    localparam logic [7:0] LCD_SHIFT_L = 8'h18;
    localparam logic [7:0] LCD_FUNC    = 8'h30;

    // Clear and return-home (0x02 and its 0x03 alias) need the long execution wait.
    function automatic logic is_long_cmd(input logic [9:0] word);
        return !word[RS_BIT] &&
               (word[7:0] == LCD_CLEAR || word[7:0] == LCD_HOME ||
                word[7:0] == (LCD_HOME | 8'h01));
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler_timer.sv
// rtl/lcd_bus_scheduler_timer.sv - loadable down-counter shared by every bus phase
module phase_timer #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    assign done = (value == '0);

    always_ff @(posedge clk) begin
        if (rst)
            value <= RST_VAL;
        else if (load)
            value <= load_val;
        else if (!done)
            value <= value - CNT_W'(1);
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// rtl/lcd_bus_scheduler.sv - round-robin owner of the HD44780 bus with E timing and execution waits
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 76000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [9:0] req0_word,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [9:0] req1_word,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       grant_id
);

    if (T_PWRUP > 2**CNT_W || T_SETUP > 2**CNT_W || T_EN > 2**CNT_W ||
        T_HOLD > 2**CNT_W || T_SHORT > 2**CNT_W || T_LONG > 2**CNT_W) begin : g_bad_cnt_w
        $error("lcd_bus_scheduler: a T_* parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

    lcd_state_e       state_q, state_d;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val, tmr_value;
    logic             last_q;
    logic             long_q;
    logic             idle;
    logic [9:0]       win_word;

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(LD_PWRUP)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    // last_q remembers who was served last; on contention the other side wins.
    assign idle       = !rst && (state_q == ST_IDLE);
    assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);
    assign win_word   = req1_ready ? req1_word : req0_word;
    assign busy       = (state_q != ST_IDLE);
    assign lcd_rw     = 1'b0;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_PWRUP: if (tmr_done) state_d = ST_IDLE;
            ST_IDLE: if (req0_ready || req1_ready) begin
                state_d  = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = LD_SETUP;
            end
            ST_SETUP: if (tmr_done) begin
                state_d  = ST_PULSE;
                tmr_load = 1'b1;
                tmr_val  = LD_EN;
            end
            ST_PULSE: if (tmr_done) begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = LD_HOLD;
            end
            ST_HOLD: if (tmr_done) begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = long_q ? LD_LONG : LD_SHORT;
            end
            ST_WAIT: if (tmr_done) state_d = ST_IDLE;
            default: state_d = ST_PWRUP;
        endcase
    end

    // E is registered from the next state so it tracks PULSE exactly and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PWRUP;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= '0;
            grant_id <= 1'b0;
            last_q   <= 1'b1;
            long_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lcd_e   <= (state_d == ST_PULSE);
            if (req0_ready || req1_ready) begin
                grant_id <= req1_ready;
                last_q   <= req1_ready;
                lcd_rs   <= win_word[RS_BIT];
                lcd_db   <= win_word[7:0];
                long_q   <= is_long_cmd(win_word);
            end
        end
    end

    a_idle_timer_clear: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_IDLE) |-> (tmr_value == '0));

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb/tb_lcd_bus_scheduler.sv - self-checking bench for lcd_bus_scheduler
module tb_lcd_bus_scheduler;

    localparam int TP = 10, TS = 2, TE = 3, TH = 1, TSH = 20, TL = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_word = '0, req1_word = '0;
    logic       req0_ready, req1_ready;
    logic       lcd_rs, lcd_rw, lcd_e, busy, grant_id;
    logic [7:0] lcd_db;

    lcd_bus_scheduler #(
        .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
        .T_SHORT(TSH), .T_LONG(TL), .CNT_W(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_word  (req0_word),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_word  (req1_word),
        .req1_ready (req1_ready),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_db     (lcd_db),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: n is the number of edges seen; outputs follow from edge distances.
    int         n = 0;
    bit         m_started = 1'b0;
    int         m_rst = 0;
    bit         m_has = 1'b0;
    int         m_k = 0;
    bit         m_long = 1'b0;
    bit         m_last = 1'b1;
    bit         m_gid = 1'b0;
    bit         m_rs = 1'b0;
    int         m_db = 0;
    logic [9:0] m_w;
    bit         h0, h1;

    function automatic int m_total();
        return TS + TE + TH + (m_long ? TL : TSH);
    endfunction

    function automatic bit m_busy();
        return (n - m_rst < TP) || (m_has && (n - m_k < m_total()));
    endfunction

    function automatic bit m_rdy0();
        return !rst && !m_busy() && req0_valid && (!req1_valid || m_last);
    endfunction

    function automatic bit m_rdy1();
        return !rst && !m_busy() && req1_valid && (!req0_valid || !m_last);
    endfunction

    function automatic bit m_e();
        return m_has && (n - m_k >= TS) && (n - m_k < TS + TE);
    endfunction

    always @(posedge clk) begin
        h0 = m_started && m_rdy0();
        h1 = m_started && m_rdy1();
        if (rst) begin
            m_started = 1'b1;
            m_rst     = n + 1;
            m_has     = 1'b0;
            m_last    = 1'b1;
            m_gid     = 1'b0;
            m_rs      = 1'b0;
            m_db      = 0;
        end else if (h0 || h1) begin
            m_w    = h1 ? req1_word : req0_word;
            m_k    = n + 1;
            m_has  = 1'b1;
            m_last = h1;
            m_gid  = h1;
            m_rs   = m_w[9];
            m_db   = int'(m_w[7:0]);
            m_long = !m_w[9] && (m_w[7:0] >= 8'h01) && (m_w[7:0] <= 8'h03);
        end
        n = n + 1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("req0_ready", int'(req0_ready), int'(m_rdy0()));
            check("req1_ready", int'(req1_ready), int'(m_rdy1()));
            check("lcd_e",      int'(lcd_e),      int'(m_e()));
            check("lcd_rs",     int'(lcd_rs),     int'(m_rs));
            check("lcd_db",     int'(lcd_db),     m_db);
            check("lcd_rw",     int'(lcd_rw),     0);
            check("busy",       int'(busy),       int'(m_busy()));
            check("grant_id",   int'(grant_id),   int'(m_gid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Labels are edge distances from base plus one: a handshake at edge k labels its first bus cycle 1.
    task automatic wait_rdy(input int base, output int lab, output int ef, output int ec);
        bit found = 1'b0;
        lab = -1;
        ef  = -1;
        ec  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (lcd_e) begin
                ec++;
                if (ef < 0) ef = n + 1 - base;
            end
            if (req0_ready || req1_ready) begin
                lab   = n + 1 - base;
                found = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_idle(output int cnt, output int ec);
        bit found = 1'b0;
        cnt = 0;
        ec  = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (!busy) begin
                found = 1'b1;
            end else begin
                if (lcd_e) ec++;
                tick();
                cnt++;
            end
        end
        if (!found) cnt = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int k, r, lab, ef, ec, cnt;

    initial begin
        // power-up with a command already waiting
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_word  = 10'h030;
        repeat (3) tick();
        r   = n;
        rst = 1'b0;
        wait_rdy(r, lab, ef, ec);
        check("pwrup_len", lab - 1, 10);
        check("pwrup_no_e", ec, 0);

        tick();
        k = n;
        req0_word = 10'h241;
        wait_rdy(k, lab, ef, ec);
        check("func_ready", lab, 27);

        // single data write 'A'
        tick();
        k = n;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_word  = 10'h001;
        wait_rdy(k, lab, ef, ec);
        check("data_e_rise", ef, 3);
        check("data_e_len", ec, 3);
        check("data_ready", lab, 27);
        check("data_db", int'(lcd_db), 'h41);
        check("data_rs", int'(lcd_rs), 1);

        // long clear from requester 1
        tick();
        k = n;
        req1_word = 10'h018;
        wait_rdy(k, lab, ef, ec);
        check("clear_ready", lab, 107);
        check("clear_gid", int'(grant_id), 1);

        // shift is a short command
        tick();
        k = n;
        req0_word  = 10'h248;
        req1_word  = 10'h249;
        req0_valid = 1'b1;
        wait_rdy(k, lab, ef, ec);
        check("shift_ready", lab, 27);

        // contention: strict alternation starting with requester 0
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_rdy(k, lab, ef, ec);
            check("cont_port", int'(req1_ready), i % 2);
            tick();
            k = n;
            check("cont_gid", int'(grant_id), i % 2);
            check("cont_db", int'(lcd_db), 'h48 + (i % 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // reset in the middle of the E pulse
        wait_idle(cnt, ec);
        req0_valid = 1'b1;
        req0_word  = 10'h241;
        wait_rdy(n, lab, ef, ec);
        tick();
        req0_valid = 1'b0;
        repeat (TS) tick();
        check("pulse_before_rst", int'(lcd_e), 1);
        rst = 1'b1;
        tick();
        check("rst_e", int'(lcd_e), 0);
        check("rst_db", int'(lcd_db), 0);
        check("rst_busy", int'(busy), 1);
        rst = 1'b0;
        wait_idle(cnt, ec);
        check("rst_pwrup_len", cnt, 10);
        check("rst_no_e", ec, 0);

        // a valid pulse during WAIT that never handshakes
        req0_valid = 1'b1;
        req0_word  = 10'h241;
        tick();
        req0_valid = 1'b0;
        repeat (10) tick();
        req1_valid = 1'b1;
        req1_word  = 10'h249;
        tick();
        req1_valid = 1'b0;
        ec = 0;
        for (int i = 0; i < 40; i++) begin
            if (lcd_e) ec++;
            tick();
        end
        check("withdraw_no_e", ec, 0);
        check("withdraw_idle", int'(busy), 0);
        check("withdraw_db", int'(lcd_db), 'h41);
        check("withdraw_gid", int'(grant_id), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
